// File: rtl/booth_mul_seq_pkg.sv
// rtl/booth_mul_seq_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    PM   = 3'd1,
    P2M  = 3'd2,
    NM   = 3'd3,
    N2M  = 3'd4
  } booth_digit_t;

  // Number of radix-4 digits needed to cover a width-bit operand extended by two bits
  function automatic int iter_count(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_mul_seq_if.sv
// rtl/booth_mul_seq_if.sv - operand/product handshake bundle for booth_mul_seq
interface booth_mul_seq_if #(parameter int WIDTH = 32);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   c;
  logic                 busy;

  modport master (
    output flush, in_valid, a, b, is_signed, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  flush, in_valid, a, b, is_signed, out_ready,
    output in_ready, out_valid, c, busy
  );

endinterface

// File: rtl/booth_mul_seq_booth4_sel.sv
// rtl/booth_mul_seq_booth4_sel.sv - radix-4 Booth partial product selector
module booth4_sel
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+2:0] pp
);

  booth_digit_t     digit;
  logic [WIDTH+2:0] m1;
  logic [WIDTH+2:0] m2;

  // M sign-extended one more bit so 2M and the negations never overflow
  assign m1 = {m[WIDTH+1], m};
  assign m2 = {m, 1'b0};

  // Recode the 3-bit window into a Booth digit
  always_comb begin
    digit = ZERO;
    case (win)
      3'b001, 3'b010: digit = PM;
      3'b011:         digit = P2M;
      3'b100:         digit = N2M;
      3'b101, 3'b110: digit = NM;
      default:        digit = ZERO;
    endcase
  end

  // Select the partial product; negatives are two's complement at full width
  always_comb begin
    pp = '0;
    case (digit)
      PM:      pp = m1;
      P2M:     pp = m2;
      NM:      pp = -m1;
      N2M:     pp = -m2;
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// rtl/booth_mul_seq.sv - sequential radix-4 Booth multiplier, signed/unsigned, valid/ready
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  booth_mul_seq_if.slave  bus
);

  localparam int ITER = iter_count(WIDTH);
  localparam int CW   = $clog2(ITER);
  localparam int AW   = WIDTH + 3;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [AW-1:0]        acc;
  logic [AW-1:0]        mulreg;
  logic [WIDTH+1:0]     mcand;
  logic [2*WIDTH-1:0]   c_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [WIDTH+1:0]     ext_a;
  logic [WIDTH+1:0]     ext_b;
  logic [AW-1:0]        pp;
  logic [AW-1:0]        sum;
  logic [AW-1:0]        acc_nx;
  logic [AW-1:0]        mul_nx;
  logic [2*WIDTH-1:0]   c_nx;
  logic                 in_ready;
  logic                 accept;

  // Sign- or zero-extend so one datapath covers both modes
  assign ext_a = bus.is_signed ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
  assign ext_b = bus.is_signed ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

  assign in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept   = bus.in_valid & in_ready & ~bus.flush;

  booth4_sel #(.WIDTH(WIDTH)) u_sel (
    .win (mulreg[2:0]),
    .m   (mcand),
    .pp  (pp)
  );

  // Add the partial product, then shift {acc, mulreg} arithmetically right by two
  assign sum    = acc + pp;
  assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign mul_nx = {sum[1:0], mulreg[AW-1:2]};

  // After the last shift the product sits one bit up; bit 0 is a leftover multiplier bit
  assign c_nx = {acc_nx[WIDTH-3:0], mul_nx[AW-1:1]};

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.c         = c_q;
  assign bus.busy      = busy_q;

  // Control FSM with counter, shift datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      mulreg      <= '0;
      mcand       <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state       <= IDLE;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= ext_a;
            mulreg <= {ext_b, 1'b0};
            acc    <= '0;
            cnt    <= '0;
            state  <= ACC;
            busy_q <= 1'b1;
          end
        end
        ACC: begin
          acc    <= acc_nx;
          mulreg <= mul_nx;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            c_q         <= c_nx;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              mcand  <= ext_a;
              mulreg <= {ext_b, 1'b0};
              acc    <= '0;
              cnt    <= '0;
              state  <= ACC;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// tb/tb_booth_mul_seq.sv - self-checking bench for booth_mul_seq at WIDTH=32 and WIDTH=8
module tb_booth_mul_seq;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  booth_mul_seq_if #(.WIDTH(32)) bus32 ();
  booth_mul_seq_if #(.WIDTH(8))  bus8 ();

  booth_mul_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
  booth_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product of the interpreted operands, kept modulo 2^(2W)
  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'({32'd0, a});
    y = s ? longint'($signed(b)) : longint'({32'd0, b});
    return 64'(x * y);
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int x, y;
    x = s ? int'($signed(a)) : int'({24'd0, a});
    y = s ? int'($signed(b)) : int'({24'd0, b});
    return 16'(x * y);
  endfunction

  // Launch one 32-bit op, scramble the operand pins afterwards, return latency and product
  task automatic do_op32(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic ordy, output int lat, output logic [63:0] prod);
    if (bus32.out_valid) begin
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus32.out_ready = ordy;
    bus32.a = a; bus32.b = b; bus32.is_signed = s; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.a = $urandom; bus32.b = $urandom; bus32.is_signed = ~s;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus32.out_valid) break;
      @(posedge clk); #1;
      if (bus32.out_valid) lat = i;
    end
    prod = bus32.c;
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output logic [15:0] prod);
    if (bus8.out_valid) begin
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus8.out_ready = 1'b1;
    bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
    @(posedge clk); #1;
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.is_signed = ~s;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus8.out_valid) break;
      @(posedge clk); #1;
      if (bus8.out_valid) lat = i;
    end
    prod = bus8.c;
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid); else n_pass++;
    n_total++; if (bus32.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus32.busy); else n_pass++;
    n_total++; if (bus32.c !== 64'd0) $display("FAIL reset_c: got %h want 0", bus32.c); else n_pass++;
    n_total++; if (bus8.c !== 16'd0) $display("FAIL reset_c8: got %h want 0", bus8.c); else n_pass++;
    #10 rst = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready); else n_pass++;
  endtask

  task automatic test_directed;
    logic [31:0] ta [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                            32'h80000000, 32'h80000000, 32'h0, 32'h0};
    logic [31:0] tb [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 32'h2,
                            32'h80000000, 32'h7FFFFFFF, 32'hDEADBEEF, 32'hDEADBEEF};
    logic        ts [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [63:0] te [8] = '{64'h0000000000000001, 64'hFFFFFFFE00000001,
                            64'hFFFFFFFFFFFFFFFE, 64'h00000001FFFFFFFE,
                            64'h4000000000000000, 64'hC000000080000000,
                            64'h0, 64'h0};
    int          lat;
    logic [63:0] p;
    for (int i = 0; i < 8; i++) begin
      do_op32(ta[i], tb[i], ts[i], 1'b1, lat, p);
      n_total++; if (p !== te[i]) $display("FAIL directed_%0d: got %h want %h", i, p, te[i]); else n_pass++;
      n_total++; if (lat !== 17) $display("FAIL directed_lat_%0d: got %0d want 17", i, lat); else n_pass++;
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    logic        s;
    int          lat;
    logic [63:0] p, e;
    for (int i = 0; i < 24; i++) begin
      a = (i % 6 == 0) ? 32'd0 : $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      e = ref32(a, b, s);
      do_op32(a, b, s, 1'b1, lat, p);
      n_total++; if (p !== e || lat !== 17) $display("FAIL random_%0d: got %h lat %0d want %h lat 17", i, p, lat, e); else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    int          lat;
    logic [63:0] p, held;
    logic [31:0] a2, b2;
    bit          ok;
    do_op32(32'd123456789, 32'hFFFFFF00, 1'b1, 1'b0, lat, p);
    n_total++; if (p !== ref32(32'd123456789, 32'hFFFFFF00, 1'b1)) $display("FAIL bp_first: got %h want %h", p, ref32(32'd123456789, 32'hFFFFFF00, 1'b1)); else n_pass++;
    held = p;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 || bus32.c !== held) ok = 1'b0;
    end
    n_total++; if (!ok) $display("FAIL bp_stall: got ov=%b ir=%b c=%h want ov=1 ir=0 c=%h", bus32.out_valid, bus32.in_ready, bus32.c, held); else n_pass++;
    a2 = $urandom; b2 = $urandom;
    bus32.a = a2; bus32.b = b2; bus32.is_signed = 1'b0; bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    #1;
    n_total++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_in_ready_comb: got %b want 1", bus32.in_ready); else n_pass++;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    n_total++; if (bus32.out_valid !== 1'b0 || bus32.busy !== 1'b1) $display("FAIL b2b_accept: got ov=%b busy=%b want ov=0 busy=1", bus32.out_valid, bus32.busy); else n_pass++;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid) begin lat = i; break; end
    end
    n_total++; if (lat !== 17 || bus32.c !== ref32(a2, b2, 1'b0)) $display("FAIL b2b_result: got %h lat %0d want %h lat 17", bus32.c, lat, ref32(a2, b2, 1'b0)); else n_pass++;
  endtask

  task automatic test_flush;
    int          lat;
    logic [63:0] p;
    bit          seen;
    if (bus32.out_valid) begin bus32.out_ready = 1'b1; @(posedge clk); #1; end
    bus32.a = 32'd99; bus32.b = 32'd77; bus32.is_signed = 1'b0; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    bus32.flush = 1'b1;
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    n_total++; if (bus32.busy !== 1'b0 || bus32.out_valid !== 1'b0) $display("FAIL flush_acc: got busy=%b ov=%b want 0 0", bus32.busy, bus32.out_valid); else n_pass++;
    bus32.flush = 1'b1; bus32.in_valid = 1'b1;
    @(posedge clk); #1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0;
    n_total++; if (bus32.busy !== 1'b0) $display("FAIL flush_vs_in_valid: got busy=%b want 0", bus32.busy); else n_pass++;
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (bus32.out_valid) seen = 1'b1; end
    n_total++; if (seen) $display("FAIL flush_no_result: got out_valid=1 want 0"); else n_pass++;
    do_op32(32'd7, 32'hFFFFFFFD, 1'b1, 1'b1, lat, p);
    n_total++; if (p !== 64'hFFFFFFFFFFFFFFEB || lat !== 17) $display("FAIL flush_next_op: got %h lat %0d want ffffffffffffffeb lat 17", p, lat); else n_pass++;
    do_op32(32'd5, 32'd6, 1'b0, 1'b0, lat, p);
    bus32.flush = 1'b1; bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.flush = 1'b0;
    n_total++; if (bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0 || bus32.c !== 64'd30) $display("FAIL flush_done: got ov=%b busy=%b c=%h want 0 0 1e", bus32.out_valid, bus32.busy, bus32.c); else n_pass++;
  endtask

  task automatic test_async_reset;
    int          lat;
    logic [63:0] p;
    bus32.a = $urandom; bus32.b = $urandom; bus32.is_signed = 1'b1; bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b0;
    #1;
    n_total++; if (bus32.out_valid !== 1'b0 || bus32.busy !== 1'b0 || bus32.c !== 64'd0) $display("FAIL async_reset: got ov=%b busy=%b c=%h want 0 0 0", bus32.out_valid, bus32.busy, bus32.c); else n_pass++;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    do_op32(32'd1000, 32'd1000, 1'b0, 1'b1, lat, p);
    n_total++; if (p !== 64'h00000000000F4240 || lat !== 17) $display("FAIL after_reset_op: got %h lat %0d want f4240 lat 17", p, lat); else n_pass++;
  endtask

  task automatic test_width8;
    int          lat;
    logic [15:0] p, e;
    logic [7:0]  a, b;
    logic        s;
    do_op8(8'hFF, 8'hFF, 1'b0, lat, p);
    n_total++; if (p !== 16'hFE01 || lat !== 5) $display("FAIL w8_ff_ff: got %h lat %0d want fe01 lat 5", p, lat); else n_pass++;
    do_op8(8'h80, 8'h80, 1'b1, lat, p);
    n_total++; if (p !== 16'h4000) $display("FAIL w8_min_min: got %h want 4000", p); else n_pass++;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom_range(0, 1));
      e = ref8(a, b, s);
      do_op8(a, b, s, lat, p);
      n_total++; if (p !== e || lat !== 5) $display("FAIL w8_random_%0d: got %h lat %0d want %h lat 5", i, p, lat, e); else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0;
    bus32.is_signed = 1'b0; bus32.out_ready = 1'b1;
    bus8.flush = 1'b0; bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0;
    bus8.is_signed = 1'b0; bus8.out_ready = 1'b1;
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_flush;
    test_async_reset;
    test_width8;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Parametrised sequential multiplier using radix-4 Booth recoding. It replaces the fixed 32-bit radix-2 unit.
- Adds a selectable signed/unsigned mode per operation.
- Uses valid/ready handshakes on both input and output, and supports a synchronous flush.
- Sits beside the ALU in the EX stage. It serves MULT/MULTU and writes the HI/LO pair through the output channel.

Parameters:
- WIDTH, 32, operand width in bits; must be even and ≥4.
- ITER, WIDTH/2+1, number of Booth digits processed (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort: drops the in-flight operation and any held result.
- in_valid  in  1  operand request.
- in_ready  out  1  unit can accept operands this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned operands.
- out_valid  out  1  product available.
- out_ready  in  1  consumer takes the product.
- c  out  2*WIDTH  product {HI,LO}.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, accumulator=0, c=0, out_valid=0, busy=0. in_ready=1 once rst is released.
- Operand extension at accept, to WIDTH+2 bits:
  - is_signed=1: sign-extend.
  - is_signed=0: zero-extend.
  - This gives one datapath for both modes.
- Multiplier register holds {ext_b, 1'b0}. Each cycle the Booth digit is the low 3 bits, mapped as follows:
  - 000 / 111 → 0
  - 001 / 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 / 110 → −M
- −M and −2M are formed as two's complement of M at WIDTH+3 bits. No extra carry cycle.
- After each add, the {acc, mulreg} pair is shifted arithmetically right by 2.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready: latch the extended operands, clear acc, counter=0, go to ACC.
  - ACC: one digit per clk. Counter increments. When counter==ITER−1 on this edge, go to DONE.
  - DONE: out_valid=1 and c holds the low 2*WIDTH bits of the product, stable until the handshake.
    - On out_ready with no in_valid: go to IDLE.
    - On out_ready with in_valid: accept the new operands the same cycle and go directly to ACC (back-to-back).
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from out_ready.
- Latency: out_valid rises exactly ITER cycles after the accept edge (17 cycles for WIDTH=32). Throughput is one result per ITER+1 cycles when out_ready is held at 1.
- Operand stability: a, b and is_signed are sampled only at the accept edge. Later changes have no effect.
- Stall: while in DONE with out_ready=0, c and out_valid hold indefinitely and in_ready=0.
- Flush=1 at a clock edge (any state): go to IDLE, out_valid=0, counter=0. The result is discarded.
  - Flush wins over a simultaneous in_valid; no operand is accepted in that cycle.
  - Flush wins over a simultaneous out_ready; no handshake occurs.
- Reset mid-operation: immediate return to the reset values. No partial result is ever output.
- c is registered and updated only on the transition into DONE. Otherwise it keeps its last value; after flush it keeps its last value too, qualified by out_valid=0.
- Width rule: the internal accumulator is WIDTH+3 bits. The final product is {acc, mulreg} truncated to 2*WIDTH bits, which is exact in both modes.

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE, ACC, DONE), 2-bit encoding;
  - the Booth digit enum (ZERO, PM, P2M, NM, N2M);
  - the function iter_count(width) = width/2+1.
- Sub-module booth4_sel (combinational):
  - inputs: 3-bit window, M;
  - output: the selected partial product (WIDTH+3 bits).
  - It is reused by a future pipelined variant.
- The FSM, counter and shift datapath stay in booth_mul_seq.

Test Plan:
- Signed: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=1 → c=0x0000000000000001, out_valid exactly 17 cycles after accept.
- Unsigned: a=0xFFFFFFFF, b=0xFFFFFFFF, is_signed=0 → c=0xFFFFFFFE00000001. With a=0xFFFFFFFF, b=2: signed → 0xFFFFFFFFFFFFFFFE, unsigned → 0x00000001FFFFFFFE.
- Corner cases:
  - a=0x80000000, b=0x80000000 signed → 0x4000000000000000.
  - a=0x80000000, b=0x7FFFFFFF signed → 0xC000000080000000.
  - a=0, b=any → 0.
- Back-pressure: out_ready=0 for 10 cycles after out_valid → c and out_valid stable and in_ready=0. Then out_ready=1 together with in_valid=1 → new op accepted that cycle, next result 17 cycles later.
- Flush at ACC cycle 5 → out_valid never rises, busy=0 next cycle. Flush together with in_valid in IDLE → no accept. The following op (7×−3 signed) → 0xFFFFFFFFFFFFFFEB.
- Async reset asserted mid-ACC, between clock edges → out_valid=0, busy=0 immediately. After release, a 1000×1000 unsigned op → 0x00000000000F4240. Repeat with WIDTH=8: 0xFF×0xFF unsigned → 0xFE01, latency 5.
